// File: rtl/pc_pkg.sv
// pc_pkg: shared types and default constants for the fetch-stage PC controller.
// Revision 1.0
`default_nettype none

package pc_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] IMEM_SIZE_DEF  = 32'h0000_1000;

endpackage

`default_nettype wire

// File: rtl/pc_fault_chk.sv
// pc_fault_chk: combinational alignment and instruction-memory range check of a PC value.
// Revision 1.0
`default_nettype none

module pc_fault_chk
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               ALIGN     = 2,
  parameter logic [WIDTH-1:0] IMEM_BASE = WIDTH'(IMEM_BASE_DEF),
  parameter logic [WIDTH-1:0] IMEM_SIZE = WIDTH'(IMEM_SIZE_DEF)
) (
  input  logic [WIDTH-1:0] pc,
  output logic             fault
);

  logic misaligned;
  logic in_range;

  generate
    if (ALIGN > 0) begin : g_align
      assign misaligned = |pc[ALIGN-1:0];
    end else begin : g_no_align
      assign misaligned = 1'b0;
    end
  endgenerate

  // Subtract-then-compare keeps the window test correct even if BASE+SIZE wraps.
  assign in_range = (pc >= IMEM_BASE) && ((pc - IMEM_BASE) < IMEM_SIZE);
  assign fault    = misaligned || !in_range;

endmodule

`default_nettype wire

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage PC register with exception/ERET/branch arbitration and stall-time branch buffering.
// Revision 1.0
`default_nettype none

module pc_ctrl
  import pc_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_PC_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEF),
  parameter int               INC        = 4,
  parameter int               ALIGN      = 2,
  parameter logic [WIDTH-1:0] IMEM_BASE  = WIDTH'(IMEM_BASE_DEF),
  parameter logic [WIDTH-1:0] IMEM_SIZE  = WIDTH'(IMEM_SIZE_DEF),
  parameter int               N_STALL    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_STALL-1:0] stall,
  input  logic               br_valid,
  input  logic [WIDTH-1:0]   br_target,
  input  logic               exc_req,
  input  logic               eret_req,
  input  logic [WIDTH-1:0]   epc,
  output logic [WIDTH-1:0]   pc,
  output logic               fetch_fault,
  output logic               pending,
  output logic               redirect_drop
);

  pc_state_e        state, state_nxt;
  logic [WIDTH-1:0] pend_target, pend_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic             drop_nxt;
  logic             fault_nxt;
  logic             fault_rst;
  logic             stall_any;

  assign stall_any = |stall;

  always_comb begin
    pc_nxt    = pc;
    state_nxt = state;
    pend_nxt  = pend_target;
    drop_nxt  = 1'b0;
    if (exc_req) begin
      pc_nxt    = EXC_VECTOR;
      state_nxt = RUN;
    end else if (eret_req) begin
      pc_nxt    = epc;
      state_nxt = RUN;
    end else if (state == RUN) begin
      if (stall_any) begin
        if (br_valid) begin
          pend_nxt  = br_target;
          state_nxt = PEND;
        end
      end else begin
        pc_nxt = br_valid ? br_target : pc + WIDTH'(INC);
      end
    end else begin
      // A newer branch while buffered replaces the old one; on release the buffered one wins.
      if (stall_any) begin
        if (br_valid) begin
          pend_nxt = br_target;
          drop_nxt = 1'b1;
        end
      end else begin
        pc_nxt    = pend_target;
        state_nxt = RUN;
        drop_nxt  = br_valid;
      end
    end
  end

  pc_fault_chk #(
    .WIDTH    (WIDTH),
    .ALIGN    (ALIGN),
    .IMEM_BASE(IMEM_BASE),
    .IMEM_SIZE(IMEM_SIZE)
  ) u_fault_nxt (
    .pc   (pc_nxt),
    .fault(fault_nxt)
  );

  // Constant-input instance supplies the fault flag for the reset PC.
  pc_fault_chk #(
    .WIDTH    (WIDTH),
    .ALIGN    (ALIGN),
    .IMEM_BASE(IMEM_BASE),
    .IMEM_SIZE(IMEM_SIZE)
  ) u_fault_rst (
    .pc   (RESET_PC),
    .fault(fault_rst)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc            <= RESET_PC;
      state         <= RUN;
      pend_target   <= '0;
      redirect_drop <= 1'b0;
      fetch_fault   <= fault_rst;
    end else begin
      pc            <= pc_nxt;
      state         <= state_nxt;
      pend_target   <= pend_nxt;
      redirect_drop <= drop_nxt;
      fetch_fault   <= fault_nxt;
    end
  end

  assign pending = (state == PEND);

endmodule

`default_nettype wire

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed vector table plus randomized run against a queue-based reference model.
// Revision 1.0
`default_nettype none

module tb_pc_ctrl;

  typedef struct {
    logic [1:0]  stall;
    logic        br;
    logic [31:0] tgt;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] e_pc;
    logic        e_fault;
    logic        e_pend;
    logic        e_drop;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic        fetch_fault;
  logic        pending;
  logic        redirect_drop;

  int nvec = 0;
  int nerr = 0;

  // Reference model state: a queue of at most one buffered target.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_drop;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .epc          (epc),
    .pc           (pc),
    .fetch_fault  (fetch_fault),
    .pending      (pending),
    .redirect_drop(redirect_drop)
  );

  function automatic logic fault_of(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a >= 32'h4000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h3000;
    m_q.delete();
    m_drop = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] s, input logic b, input logic [31:0] t,
                            input logic e, input logic r, input logic [31:0] ep);
    m_drop = 1'b0;
    if (e) begin
      m_pc = 32'h4180;
      m_q.delete();
    end else if (r) begin
      m_pc = ep;
      m_q.delete();
    end else if (s != 2'b00) begin
      if (b) begin
        if (m_q.size() > 0) begin
          m_q[0] = t;
          m_drop = 1'b1;
        end else begin
          m_q.push_back(t);
        end
      end
    end else if (m_q.size() > 0) begin
      m_pc   = m_q.pop_front();
      m_drop = b;
    end else begin
      m_pc = b ? t : m_pc + 32'd4;
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic b, input logic [31:0] t,
                       input logic e, input logic r, input logic [31:0] ep);
    stall = s; br_valid = b; br_target = t; exc_req = e; eret_req = r; epc = ep;
    @(posedge clk);
    #1;
    model_step(s, b, t, e, r, ep);
  endtask

  task automatic idle();
    stall = 2'b00; br_valid = 1'b0; br_target = '0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0;
  endtask

  vec_t vecs[$];

  initial begin
    //            stall  br  tgt           exc   eret  epc           pc            flt   pend  drop
    vecs.push_back('{2'b00, 0, 32'h0,    0, 0, 32'h0,    32'h3004, 0, 0, 0});
    vecs.push_back('{2'b00, 0, 32'h0,    0, 0, 32'h0,    32'h3008, 0, 0, 0});
    vecs.push_back('{2'b00, 0, 32'h0,    0, 0, 32'h0,    32'h300C, 0, 0, 0});
    vecs.push_back('{2'b00, 1, 32'h3008, 0, 0, 32'h0,    32'h3008, 0, 0, 0});
    vecs.push_back('{2'b01, 1, 32'h3100, 0, 0, 32'h0,    32'h3008, 0, 1, 0});
    vecs.push_back('{2'b01, 0, 32'h0,    0, 0, 32'h0,    32'h3008, 0, 1, 0});
    vecs.push_back('{2'b01, 0, 32'h0,    0, 0, 32'h0,    32'h3008, 0, 1, 0});
    vecs.push_back('{2'b00, 0, 32'h0,    0, 0, 32'h0,    32'h3100, 0, 0, 0});
    vecs.push_back('{2'b10, 1, 32'h3100, 0, 0, 32'h0,    32'h3100, 0, 1, 0});
    vecs.push_back('{2'b10, 1, 32'h3200, 0, 0, 32'h0,    32'h3100, 0, 1, 1});
    vecs.push_back('{2'b10, 0, 32'h0,    0, 0, 32'h0,    32'h3100, 0, 1, 0});
    vecs.push_back('{2'b00, 0, 32'h0,    0, 0, 32'h0,    32'h3200, 0, 0, 0});
    vecs.push_back('{2'b11, 1, 32'h3300, 0, 0, 32'h0,    32'h3200, 0, 1, 0});
    // Exception wins over stall, discards the buffer, and its coincident branch drops silently.
    vecs.push_back('{2'b11, 1, 32'h3400, 1, 0, 32'h0,    32'h4180, 1, 0, 0});
    vecs.push_back('{2'b00, 0, 32'h0,    0, 1, 32'h3010, 32'h3010, 0, 0, 0});
    vecs.push_back('{2'b00, 1, 32'h3102, 0, 0, 32'h0,    32'h3102, 1, 0, 0});
    vecs.push_back('{2'b00, 0, 32'h0,    0, 0, 32'h0,    32'h3106, 1, 0, 0});
    vecs.push_back('{2'b00, 1, 32'h5000, 0, 0, 32'h0,    32'h5000, 1, 0, 0});
    vecs.push_back('{2'b00, 0, 32'h0,    0, 0, 32'h0,    32'h5004, 1, 0, 0});
    vecs.push_back('{2'b00, 1, 32'h3000, 0, 0, 32'h0,    32'h3000, 0, 0, 0});
    vecs.push_back('{2'b01, 1, 32'h3FFC, 0, 0, 32'h0,    32'h3000, 0, 1, 0});
    // Release plus a new branch: buffered target wins, new branch is dropped.
    vecs.push_back('{2'b00, 1, 32'h3500, 0, 0, 32'h0,    32'h3FFC, 0, 0, 1});
    vecs.push_back('{2'b00, 0, 32'h0,    0, 0, 32'h0,    32'h4000, 1, 0, 0});
    vecs.push_back('{2'b00, 1, 32'h2FFC, 0, 0, 32'h0,    32'h2FFC, 1, 0, 0});
    vecs.push_back('{2'b00, 0, 32'h0,    0, 0, 32'h0,    32'h3000, 0, 0, 0});
    vecs.push_back('{2'b00, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'hFFFF_FFFC, 1, 0, 0});
    vecs.push_back('{2'b00, 0, 32'h0,    0, 0, 32'h0,    32'h0000_0000, 1, 0, 0});
    // ERET loses to a simultaneous exception.
    vecs.push_back('{2'b00, 0, 32'h0,    1, 1, 32'h3010, 32'h4180, 1, 0, 0});

    idle();
    reset_n = 1'b0;
    model_reset();
    #12;
    chk("reset_pc", pc, 32'h3000);
    chk("reset_fault", {31'b0, fetch_fault}, 32'd0);
    chk("reset_pending", {31'b0, pending}, 32'd0);
    chk("reset_drop", {31'b0, redirect_drop}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].exc, vecs[i].eret, vecs[i].epc);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d_fault", i), {31'b0, fetch_fault}, {31'b0, vecs[i].e_fault});
      chk($sformatf("v%0d_pending", i), {31'b0, pending}, {31'b0, vecs[i].e_pend});
      chk($sformatf("v%0d_drop", i), {31'b0, redirect_drop}, {31'b0, vecs[i].e_drop});
    end

    // Asynchronous reset while a target is buffered: clears without a clock edge.
    drive(2'b00, 1'b1, 32'h3800, 1'b0, 1'b0, 32'h0);
    drive(2'b01, 1'b1, 32'h3900, 1'b0, 1'b0, 32'h0);
    chk("pre_areset_pending", {31'b0, pending}, 32'd1);
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("areset_pc", pc, 32'h3000);
    chk("areset_pending", {31'b0, pending}, 32'd0);
    chk("areset_drop", {31'b0, redirect_drop}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("post_areset_pc", pc, 32'h3004);

    for (int n = 0; n < 400; n++) begin
      logic [1:0]  s;
      logic        b, e, r;
      logic [31:0] t, ep;
      s  = ($urandom_range(0, 99) < 45) ? 2'($urandom_range(1, 3)) : 2'b00;
      b  = ($urandom_range(0, 99) < 40);
      t  = 32'h2FF0 + ($urandom_range(0, 32'h1030) & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC));
      e  = ($urandom_range(0, 99) < 4);
      r  = ($urandom_range(0, 99) < 4);
      ep = 32'h3000 + ($urandom_range(0, 32'h3FF) << 2);
      drive(s, b, t, e, r, ep);
      chk($sformatf("r%0d_pc", n), pc, m_pc);
      chk($sformatf("r%0d_fault", n), {31'b0, fetch_fault}, {31'b0, fault_of(m_pc)});
      chk($sformatf("r%0d_pending", n), {31'b0, pending}, {31'b0, (m_q.size() > 0)});
      chk($sformatf("r%0d_drop", n), {31'b0, redirect_drop}, {31'b0, m_drop});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
